ads131a0x_frame_unpacker: RTL
=============================

# ads131a0x_frame_unpacker

Unpacks the ADC's 24-bit SPI word stream into parallel, sign-extended per-channel sample frames. Sits directly downstream of the ADS131A0X SPI controller: it receives one word per SPI word-transfer plus a start-of-frame marker, checks the status word, and presents complete frames to the processing/LED logic over a valid/ready handshake.

## Interface
Parameters:
- NUM_CH, 4, channels per frame (2..8)
- WORD_BITS, 24, SPI word width
- OUT_BITS, 32, output sample width (≥ WORD_BITS)
- STATUS_HDR, 8'h22, required value of status word bits [WORD_BITS-1:WORD_BITS-8]

Ports:
- system_clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  when low, new frames are not started; a frame in progress completes
- word_valid  in  1  single-cycle strobe, word_data valid
- word_data  in  WORD_BITS  received SPI word, MSB first as shifted
- frame_start  in  1  qualified by word_valid; marks the status word (first word after CS fall)
- frame_valid  out  1  parallel frame available
- frame_ready  in  1  consumer accepts frame when high with frame_valid
- samples  out  NUM_CH*OUT_BITS  channel k at bits [k*OUT_BITS +: OUT_BITS]
- status_word  out  16  word_data[WORD_BITS-1:WORD_BITS-16] of the frame's status word
- frame_count  out  16  committed frames, wraps
- err_header  out  1  one-cycle pulse: status header mismatch
- err_short  out  1  one-cycle pulse: frame_start arrived before NUM_CH channel words
- err_overrun  out  1  one-cycle pulse: completed frame dropped, output still held
- busy  out  1  high in COLLECT

## Operation
- States: IDLE, COLLECT.
- IDLE: word_valid & frame_start & enable -> check header. Match: latch status into staging, ch_idx=0, -> COLLECT. Mismatch: err_header pulse, stay IDLE. word_valid without frame_start ignored.
- COLLECT: each word_valid without frame_start writes sign-extended word to staging[ch_idx], ch_idx++. On the NUM_CH-th word: commit, -> IDLE.
- COLLECT, word_valid & frame_start: err_short pulse, partial frame discarded, word treated as new status word exactly as in IDLE (enable and header rules apply).
- Sign extension: sample = {(OUT_BITS-WORD_BITS){word[WORD_BITS-1]}, word}.
- Commit: if !frame_valid or (frame_valid & frame_ready) this cycle -> samples/status_word loaded from staging, frame_valid=1, frame_count++ (16'hFFFF -> 0). Else frame dropped, err_overrun pulse, outputs and frame_count unchanged.
- Output register: frame_valid clears on frame_valid & frame_ready unless a commit occurs in the same cycle (then stays high, new data).
- Staging is separate from output; output never changes while frame_valid high and not accepted.

## Timing
- All outputs registered. Reset values: frame_valid=0, samples=0, status_word=0, frame_count=0, all err_*=0, busy=0; state IDLE, ch_idx=0.
- Latency: last channel word sampled at edge N -> frame_valid/samples updated at edge N (visible cycle N+1). One-cycle latency.
- err_* pulses high exactly one cycle, asserted the cycle after the causing word.
- busy high from cycle after accepted status word through the cycle the last channel word is sampled.
- Back-to-back words on consecutive cycles supported; no minimum gap.
- Reset mid-frame: partial frame discarded, outputs to reset values next cycle.
- enable deasserted in COLLECT: frame completes normally; subsequent frame_start ignored (err_short still pulses if it interrupts a partial frame).

## Test plan
- Nominal: status 24'h22_0000, words 24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF, frame_ready=1 -> samples 32'h1, 32'h7FFFFF, 32'hFF800000, 32'hFFFFFFFF; status_word 16'h2200; frame_count 1; frame_valid one cycle after 4th word.
- Header error: status 24'h11_0000 then 4 words -> err_header one pulse, no frame_valid, frame_count 0.
- Short frame: status, 2 channel words, new status + 4 words -> err_short one pulse, single frame with the last 4 words, frame_count 1.
- Overrun: frame_ready=0, two full frames -> first frame held unchanged, err_overrun on second commit, frame_count 1; raise frame_ready -> frame_valid drops next cycle.
- Simultaneous accept/commit: frame_ready=1 in the commit cycle of frame 2 while frame 1 valid -> frame_valid stays high, samples switch to frame 2, no err_overrun, frame_count 2.
- Reset mid-frame after 2 channel words, then a full frame -> all outputs zero after reset, next frame correct, frame_count 1; count wrap: preload 65535 frames (or force) -> next commit gives 0.

Source files
------------

// File: rtl/ads131a0x_frame_unpacker.sv
// Gathers status + NUM_CH channel words into a sign-extended parallel frame; one-cycle latency from last word.
// Output frame holds until accepted; a frame completing while the output is still held is dropped (err_overrun).
module ads131a0x_frame_unpacker #(
    parameter int          NUM_CH     = 4,
    parameter int          WORD_BITS  = 24,
    parameter int          OUT_BITS   = 32,
    parameter logic [7:0]  STATUS_HDR = 8'h22
) (
    input  logic                         system_clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         word_valid,
    input  logic [WORD_BITS-1:0]         word_data,
    input  logic                         frame_start,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [NUM_CH*OUT_BITS-1:0]   samples,
    output logic [15:0]                  status_word,
    output logic [15:0]                  frame_count,
    output logic                         err_header,
    output logic                         err_short,
    output logic                         err_overrun,
    output logic                         busy
);

    localparam int              IDX_W    = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       ch_idx;
    logic [IDX_W-1:0]       ch_idx_nxt;
    logic [OUT_BITS-1:0]    stage [NUM_CH];
    logic [15:0]            stage_status;

    logic                   hdr_ok;
    logic                   status_load;
    logic                   ch_write;
    logic                   commit;
    logic                   can_load;
    logic                   hdr_err;
    logic                   short_err;
    logic [OUT_BITS-1:0]    word_sext;
    logic [NUM_CH*OUT_BITS-1:0] frame_nxt;

    assign word_sext = OUT_BITS'($signed(word_data));
    assign hdr_ok    = (word_data[WORD_BITS-1 -: 8] == STATUS_HDR);
    assign can_load  = !frame_valid || frame_ready;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state  <= IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_nxt;
            ch_idx <= ch_idx_nxt;
        end
    end

    // A frame_start always restarts framing, whether or not a frame was in flight.
    always_comb begin
        state_nxt   = state;
        ch_idx_nxt  = ch_idx;
        status_load = 1'b0;
        ch_write    = 1'b0;
        commit      = 1'b0;
        hdr_err     = 1'b0;
        short_err   = 1'b0;
        if (word_valid) begin
            if (frame_start) begin
                short_err  = (state == COLLECT);
                state_nxt  = IDLE;
                ch_idx_nxt = '0;
                if (enable) begin
                    if (hdr_ok) begin
                        status_load = 1'b1;
                        state_nxt   = COLLECT;
                    end else begin
                        hdr_err = 1'b1;
                    end
                end
            end else if (state == COLLECT) begin
                ch_write = 1'b1;
                if (ch_idx == LAST_IDX) begin
                    commit     = 1'b1;
                    state_nxt  = IDLE;
                    ch_idx_nxt = '0;
                end else begin
                    ch_idx_nxt = ch_idx + 1'b1;
                end
            end
        end
    end

    // The last channel bypasses staging so the frame is ready on the same edge.
    always_comb begin
        frame_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == NUM_CH - 1) begin
                frame_nxt[k*OUT_BITS +: OUT_BITS] = word_sext;
            end else begin
                frame_nxt[k*OUT_BITS +: OUT_BITS] = stage[k];
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (ch_write) begin
            stage[ch_idx] <= word_sext;
        end
        if (status_load) begin
            stage_status <= word_data[WORD_BITS-1 -: 16];
        end
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            frame_valid <= 1'b0;
            samples     <= '0;
            status_word <= '0;
            frame_count <= '0;
            err_header  <= 1'b0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            err_header  <= hdr_err;
            err_short   <= short_err;
            err_overrun <= commit && !can_load;
            busy        <= (state_nxt == COLLECT);
            if (commit && can_load) begin
                samples     <= frame_nxt;
                status_word <= stage_status;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
